// File: rtl/hazard_fwd_ctrl_if.sv
// Bus between the ID/EX pipeline control and the hazard/forwarding controller.
// The master side drives the ID-stage fields and EX-stage redirects. The slave side returns the operand selects and the stall/flush strobes.
interface hazard_fwd_ctrl_if #(
    parameter int AW = 4
);
    logic [AW-1:0] id_src1_reg;
    logic          id_src1_used;
    logic [AW-1:0] id_src0_reg;
    logic          id_src0_used;
    logic [AW-1:0] id_dst_reg;
    logic          id_we;
    logic          id_mem_rd;
    logic          id_valid;
    logic          br_ctrl;
    logic          j_ctrl;
    logic [1:0]    forwardA;
    logic [1:0]    forwardB;
    logic          stall_pc;
    logic          stall_if_id;
    logic          bubble_id_ex;
    logic          flush_if_id;
    logic          flush_id_ex;

    modport master (
        output id_src1_reg, id_src1_used, id_src0_reg, id_src0_used,
               id_dst_reg, id_we, id_mem_rd, id_valid, br_ctrl, j_ctrl,
        input  forwardA, forwardB, stall_pc, stall_if_id, bubble_id_ex,
               flush_if_id, flush_id_ex
    );

    modport slave (
        input  id_src1_reg, id_src1_used, id_src0_reg, id_src0_used,
               id_dst_reg, id_we, id_mem_rd, id_valid, br_ctrl, j_ctrl,
        output forwardA, forwardB, stall_pc, stall_if_id, bubble_id_ex,
               flush_if_id, flush_id_ex
    );
endinterface

// File: rtl/hazard_fwd_ctrl.sv
// Hazard and forwarding controller for a 5-stage pipeline.
// It tracks producers in EX and MEM, registers the EX operand selects, and raises load-use stalls and branch/jump flushes.
module hazard_fwd_ctrl #(
    parameter int AW       = 4,
    parameter bit ZERO_REG = 1'b1
) (
    input logic              clk,
    input logic              rst_n,
    hazard_fwd_ctrl_if.slave bus
);

    typedef struct packed {
        logic          valid;
        logic          we;
        logic          ld;
        logic [AW-1:0] dst;
    } slot_t;

    slot_t         ex_q;
    logic          mem_wr_q;
    logic [AW-1:0] mem_dst_q;
    logic [1:0]    fwd_a_q;
    logic [1:0]    fwd_b_q;

    logic          ex_writes;
    logic          load_use;
    logic          flush;
    logic          load_ex;
    logic          id_writes;
    logic [1:0]    fwd_a_d;
    logic [1:0]    fwd_b_d;

    function automatic logic real_dst(input logic [AW-1:0] r);
        return !(ZERO_REG && (r == '0));
    endfunction

    // The youngest producer wins. A load still in EX cannot forward; that case stalls instead.
    function automatic logic [1:0] fwd_sel(
        input logic          used,
        input logic [AW-1:0] src,
        input logic          ex_alu_wr,
        input logic [AW-1:0] ex_dst,
        input logic          mem_wr,
        input logic [AW-1:0] mem_dst
    );
        if (used && ex_alu_wr && (ex_dst == src))
            return 2'b10;
        else if (used && mem_wr && (mem_dst == src))
            return 2'b01;
        else
            return 2'b00;
    endfunction

    assign ex_writes = ex_q.valid && ex_q.we && real_dst(ex_q.dst);
    assign id_writes = bus.id_we && real_dst(bus.id_dst_reg);

    assign load_use = ex_writes && ex_q.ld && bus.id_valid &&
                      ((bus.id_src1_used && (bus.id_src1_reg == ex_q.dst)) ||
                       (bus.id_src0_used && (bus.id_src0_reg == ex_q.dst)));

    // Redirect inputs are masked so that every strobe reads low while reset is asserted.
    assign flush   = (bus.br_ctrl | bus.j_ctrl) & rst_n;
    assign load_ex = bus.id_valid && !load_use && !flush;

    // NOTE: always_comb assigns every output a default first, so no path can leave a latch behind.
    always_comb begin
        fwd_a_d = 2'b00;
        fwd_b_d = 2'b00;
        if (load_ex) begin
            fwd_a_d = fwd_sel(bus.id_src1_used, bus.id_src1_reg,
                              ex_writes && !ex_q.ld, ex_q.dst, mem_wr_q, mem_dst_q);
            fwd_b_d = fwd_sel(bus.id_src0_used, bus.id_src0_reg,
                              ex_writes && !ex_q.ld, ex_q.dst, mem_wr_q, mem_dst_q);
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, and every register gets an async reset value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ex_q      <= '0;
            mem_wr_q  <= 1'b0;
            mem_dst_q <= '0;
            fwd_a_q   <= 2'b00;
            fwd_b_q   <= 2'b00;
        end else begin
            mem_wr_q  <= ex_writes;
            mem_dst_q <= ex_q.dst;
            if (load_ex) begin
                ex_q.valid <= 1'b1;
                ex_q.we    <= id_writes;
                ex_q.ld    <= bus.id_mem_rd;
                ex_q.dst   <= bus.id_dst_reg;
            end else begin
                ex_q <= '0;
            end
            fwd_a_q <= fwd_a_d;
            fwd_b_q <= fwd_b_d;
        end
    end

    // MEM is the WB stage one cycle ahead. The selects are resolved early, so no separate WB shadow is needed.
    assign bus.forwardA     = fwd_a_q;
    assign bus.forwardB     = fwd_b_q;
    assign bus.stall_pc     = load_use & ~flush;
    assign bus.stall_if_id  = load_use & ~flush;
    assign bus.bubble_id_ex = load_use & ~flush;
    assign bus.flush_if_id  = flush;
    assign bus.flush_id_ex  = flush;

endmodule

// File: tb/tb_hazard_fwd_ctrl.sv
// Directed bench for hazard_fwd_ctrl.
// The expected selects and strobes are worked out by hand from the pipeline timing.
module tb_hazard_fwd_ctrl;

    logic clk;
    logic rst_n;
    int   n_checks;
    int   n_errors;

    hazard_fwd_ctrl_if #(.AW(4)) bus ();

    hazard_fwd_ctrl #(.AW(4), .ZERO_REG(1'b1)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout, expected completion");
        $fatal(1, "bench timeout");
    end

    task automatic check(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        n_checks++;
        assert (obs === exp)
        else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [3:0] dst, input logic we, input logic ld,
                         input logic [3:0] s1, input logic u1, input logic [3:0] s0, input logic u0);
        bus.id_valid     = v;
        bus.id_dst_reg   = dst;
        bus.id_we        = we;
        bus.id_mem_rd    = ld;
        bus.id_src1_reg  = s1;
        bus.id_src1_used = u1;
        bus.id_src0_reg  = s0;
        bus.id_src0_used = u0;
    endtask

    task automatic nop();
        drive(1'b0, 4'd0, 1'b0, 1'b0, 4'd0, 1'b0, 4'd0, 1'b0);
    endtask

    task automatic cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic check_stall(input string tag, input logic exp);
        check({tag, "_stall_pc"},    {3'b0, bus.stall_pc},     {3'b0, exp});
        check({tag, "_stall_if_id"}, {3'b0, bus.stall_if_id},  {3'b0, exp});
        check({tag, "_bubble"},      {3'b0, bus.bubble_id_ex}, {3'b0, exp});
    endtask

    task automatic check_fwd(input string tag, input logic [1:0] a, input logic [1:0] b);
        check({tag, "_fwdA"}, {2'b0, bus.forwardA}, {2'b0, a});
        check({tag, "_fwdB"}, {2'b0, bus.forwardB}, {2'b0, b});
    endtask

    initial begin
        n_checks    = 0;
        n_errors    = 0;
        rst_n       = 1'b0;
        bus.br_ctrl = 1'b1;
        bus.j_ctrl  = 1'b0;
        nop();
        #2;
        // While reset is held, every output reads zero, even with a branch request present.
        check_fwd("reset", 2'b00, 2'b00);
        check_stall("reset", 1'b0);
        check("reset_flush", {3'b0, bus.flush_if_id}, 4'h0);
        bus.br_ctrl = 1'b0;
        #10 rst_n = 1'b1;

        // ADD R3 ; SUB R4,R3,R5 -> EX/MEM forward on src1
        drive(1'b1, 4'd3, 1'b1, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1); cycle();
        drive(1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 1'b1, 4'd5, 1'b1);
        #1 check_stall("alu_pair", 1'b0);
        cycle();
        check_fwd("alu_pair", 2'b10, 2'b00);
        nop(); cycle(); cycle();

        // ADD R3 ; unrelated ; consumer of R3 on src0 -> WB forward
        drive(1'b1, 4'd3, 1'b1, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1); cycle();
        drive(1'b1, 4'd8, 1'b1, 1'b0, 4'd9, 1'b1, 4'd10, 1'b1); cycle();
        check_fwd("unrelated", 2'b00, 2'b00);
        drive(1'b1, 4'd12, 1'b1, 1'b0, 4'd11, 1'b1, 4'd3, 1'b1); cycle();
        check_fwd("gap_src0", 2'b00, 2'b01);

        // ADD R3 ; unrelated ; consumer of R3 on both sources
        drive(1'b1, 4'd3, 1'b1, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1); cycle();
        drive(1'b1, 4'd8, 1'b1, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1); cycle();
        drive(1'b1, 4'd12, 1'b1, 1'b0, 4'd3, 1'b1, 4'd3, 1'b1); cycle();
        check_fwd("gap_both", 2'b01, 2'b01);
        nop(); cycle(); cycle();

        // LW R6 ; ADD R7,R6,R6 -> one stall cycle, then WB forward
        drive(1'b1, 4'd6, 1'b1, 1'b1, 4'd1, 1'b1, 4'd2, 1'b1); cycle();
        drive(1'b1, 4'd7, 1'b1, 1'b0, 4'd6, 1'b1, 4'd6, 1'b1);
        #1 check_stall("lu_first", 1'b1);
        cycle();
        check_fwd("lu_bubble", 2'b00, 2'b00);
        check_stall("lu_second", 1'b0);
        cycle();
        check_fwd("lu_after", 2'b01, 2'b01);
        nop(); cycle(); cycle();

        // LW R6 ; independent ; ADD R7,R6,R6 -> no stall, WB forward
        drive(1'b1, 4'd6, 1'b1, 1'b1, 4'd1, 1'b1, 4'd2, 1'b1); cycle();
        drive(1'b1, 4'd9, 1'b1, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1);
        #1 check_stall("lu_gap_indep", 1'b0);
        cycle();
        drive(1'b1, 4'd7, 1'b1, 1'b0, 4'd6, 1'b1, 4'd6, 1'b1);
        #1 check_stall("lu_gap_use", 1'b0);
        cycle();
        check_fwd("lu_gap", 2'b01, 2'b01);
        nop(); cycle(); cycle();

        // R0 destinations never forward or stall
        drive(1'b1, 4'd0, 1'b1, 1'b1, 4'd1, 1'b1, 4'd2, 1'b1); cycle();
        drive(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1);
        #1 check_stall("lw_r0", 1'b0);
        cycle();
        check_fwd("lw_r0", 2'b00, 2'b00);
        drive(1'b1, 4'd0, 1'b1, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1); cycle();
        drive(1'b1, 4'd5, 1'b1, 1'b0, 4'd0, 1'b1, 4'd0, 1'b1); cycle();
        check_fwd("add_r0", 2'b00, 2'b00);
        nop(); cycle(); cycle();

        // A load-use hazard in the same cycle as a taken branch: the flush wins
        drive(1'b1, 4'd6, 1'b1, 1'b1, 4'd1, 1'b1, 4'd2, 1'b1); cycle();
        drive(1'b1, 4'd7, 1'b1, 1'b0, 4'd6, 1'b1, 4'd6, 1'b1);
        bus.br_ctrl = 1'b1;
        #1;
        check("br_flush_if_id", {3'b0, bus.flush_if_id}, 4'h1);
        check("br_flush_id_ex", {3'b0, bus.flush_id_ex}, 4'h1);
        check_stall("br_lu", 1'b0);
        cycle();
        bus.br_ctrl = 1'b0;
        check_fwd("br_next", 2'b00, 2'b00);
        // The squashed R7 producer must not forward to the next instruction.
        drive(1'b1, 4'd8, 1'b1, 1'b0, 4'd7, 1'b1, 4'd2, 1'b1); cycle();
        check_fwd("br_squashed", 2'b00, 2'b00);
        nop();
        bus.j_ctrl = 1'b1;
        #1 check("jump_flush", {3'b0, bus.flush_id_ex}, 4'h1);
        cycle();
        bus.j_ctrl = 1'b0;
        cycle();

        // Reset taken mid-stream while a 2'b10 forward is pending
        drive(1'b1, 4'd3, 1'b1, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1); cycle();
        drive(1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 1'b1, 4'd5, 1'b1); cycle();
        check_fwd("pre_reset", 2'b10, 2'b00);
        nop();
        #2 rst_n = 1'b0;
        #1 check_fwd("mid_reset", 2'b00, 2'b00);
        check_stall("mid_reset", 1'b0);
        #1 rst_n = 1'b1;
        drive(1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 1'b1, 4'd3, 1'b1); cycle();
        check_fwd("post_reset_first", 2'b00, 2'b00);
        drive(1'b1, 4'd3, 1'b1, 1'b0, 4'd1, 1'b1, 4'd2, 1'b1); cycle();
        drive(1'b1, 4'd4, 1'b1, 1'b0, 4'd3, 1'b1, 4'd3, 1'b1); cycle();
        check_fwd("post_reset_pair", 2'b10, 2'b10);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
